entry_sequencer: RTL and testbench
==================================

ENTRY_SEQUENCER -- requirements
Module: entry_sequencer

Interface
REQ-001 SHALL have parameter MAX_N, default 12, meaning the largest accepted sample count.
REQ-002 SHALL have parameter W, default 8, meaning the switch and sample width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btnc, input, 1, debounced enter button (level).
REQ-006 SHALL have port btnu, input, 1, debounced abort button (level).
REQ-007 SHALL have port sw, input, W, the switch value.
REQ-008 SHALL have port smp_valid, output, 1, sample-valid to the downstream calculator.
REQ-009 SHALL have port smp_data, output, W, sample value.
REQ-010 SHALL have port smp_first, output, 1, marks the first sample of a set.
REQ-011 SHALL have port smp_last, output, 1, marks the last sample of a set.
REQ-012 SHALL have port smp_ready, input, 1, downstream accept.
REQ-013 SHALL have port set_n, output, W, the accepted sample count.
REQ-014 SHALL have port abort, output, 1, a one-cycle clear pulse to downstream.
REQ-015 SHALL have port led, output, 8, status: [3:0] remaining, [4] busy, [5] done, [6] ovr, [7] err.

Function
REQ-016 SHALL detect a button press as the current sample being 1 while the previous registered sample is 0; the previous-sample registers reset to 1, so a button held through reset gives no press.
REQ-017 SHALL implement the states IDLE, COLLECT, SEND and DONE.
REQ-018 SHALL, in IDLE or DONE on a btnc press with 1<=sw<=MAX_N: set set_n=sw, set remaining=sw, clear err and done, and go to COLLECT.
REQ-019 SHALL, in IDLE or DONE on a btnc press with sw==0 or sw>MAX_N: set err=1 and leave the state, set_n and remaining unchanged.
REQ-020 SHALL, in COLLECT on a btnc press at edge E, drive smp_valid=1 after E with: smp_data=sw; smp_first=(remaining==set_n); smp_last=(remaining==1); then go to SEND. Latency is one edge.
REQ-021 SHALL, in SEND, hold smp_valid, smp_data, smp_first and smp_last stable until an edge where smp_valid and smp_ready are both 1.
REQ-022 SHALL, on that handshake edge: clear smp_valid; decrement remaining; go to DONE if smp_last, else to COLLECT.
REQ-023 SHALL, on a btnc press in SEND, discard the press and set ovr=1 (sticky until the next accepted count).
REQ-024 SHALL, on a btnu press in any state: go to IDLE; clear smp_valid and remaining; pulse abort high for exactly one cycle. Abort has priority over a simultaneous btnc press or handshake.
REQ-025 SHALL hold done=1 from entry to DONE until the next accepted count or abort.
REQ-026 SHALL drive busy=1 in COLLECT and SEND only.
REQ-027 SHALL use only combinational decode for led; smp_first, smp_last and remaining SHALL be registered.
REQ-028 SHALL keep remaining in W bits; it never wraps because decrement occurs only on handshakes while remaining>=1.
REQ-029 SHALL, with smp_ready held 1, accept the sample on the edge after smp_valid rises, giving one sample per press.

Reset
REQ-030 SHALL, while reset_n=0 (asynchronously): set state=IDLE; smp_valid, smp_data, smp_first, smp_last, set_n, remaining, err, ovr, done and abort=0; led=0.
REQ-031 SHALL, when reset_n is asserted mid-SEND, drop smp_valid immediately with no handshake completing; the first press after release is treated as a count entry.

Verification
REQ-032 SHALL cover: sw=3, btnc press; then sw=5, 7, 9 presses with smp_ready=1 -> three handshakes with data 5,7,9; first only on 5; last only on 9; final state DONE, led=8'h20.
REQ-033 SHALL cover: sw=0 then sw=13, btnc presses in IDLE -> err=1, led[7]=1, no smp_valid; then sw=2 press -> err cleared, busy=1.
REQ-034 SHALL cover: count 2, sample press with smp_ready=0 for 10 cycles plus a second btnc press -> smp_valid and data held, ovr=1, remaining stays 2 until ready.
REQ-035 SHALL cover: count 4, two samples accepted, btnu press coincident with btnc -> abort high one cycle, state IDLE, led[3:0]=0, no third sample.
REQ-036 SHALL cover: btnc held 1 across reset release -> no count accepted until released and pressed again.
REQ-037 SHALL cover: reset_n pulsed low while smp_valid=1 -> smp_valid=0 during reset with no clock edge, and all outputs at reset values.

Source files
------------

// File: rtl/entry_sequencer.sv
// Button-driven sample entry: a count is keyed in first, then each btnc press
// emits one switch sample over a valid/ready handshake to the downstream calculator.
module entry_sequencer #(
  parameter int MAX_N = 12,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         btnc,
  input  logic         btnu,
  input  logic [W-1:0] sw,
  output logic         smp_valid,
  output logic [W-1:0] smp_data,
  output logic         smp_first,
  output logic         smp_last,
  input  logic         smp_ready,
  output logic [W-1:0] set_n,
  output logic         abort,
  output logic [7:0]   led
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SEND, S_DONE} state_t;

  localparam logic [W-1:0] MaxCount = W'(MAX_N);

  state_t       state_q;
  logic         btnc_prev_q, btnu_prev_q;
  logic         smp_valid_q, smp_first_q, smp_last_q;
  logic [W-1:0] smp_data_q, set_n_q, remaining_q;
  logic         err_q, ovr_q, done_q, abort_q;

  logic press_c, press_u, handshake, count_ok, busy;

  // Previous-sample registers reset to 1 so a button held through reset is not a press.
  assign press_c   = btnc & ~btnc_prev_q;
  assign press_u   = btnu & ~btnu_prev_q;
  assign handshake = smp_valid_q & smp_ready;
  assign count_ok  = (sw != '0) && (sw <= MaxCount);
  assign busy      = (state_q == S_COLLECT) || (state_q == S_SEND);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      btnc_prev_q <= 1'b1;
      btnu_prev_q <= 1'b1;
      smp_valid_q <= 1'b0;
      smp_data_q  <= '0;
      smp_first_q <= 1'b0;
      smp_last_q  <= 1'b0;
      set_n_q     <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      btnc_prev_q <= btnc;
      btnu_prev_q <= btnu;
      abort_q     <= 1'b0;
      if (press_u) begin
        // Abort wins over any coincident press or handshake.
        state_q     <= S_IDLE;
        smp_valid_q <= 1'b0;
        remaining_q <= '0;
        done_q      <= 1'b0;
        abort_q     <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (press_c) begin
              if (count_ok) begin
                set_n_q     <= sw;
                remaining_q <= sw;
                err_q       <= 1'b0;
                done_q      <= 1'b0;
                ovr_q       <= 1'b0;
                state_q     <= S_COLLECT;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_COLLECT: begin
            if (press_c) begin
              smp_valid_q <= 1'b1;
              smp_data_q  <= sw;
              smp_first_q <= (remaining_q == set_n_q);
              smp_last_q  <= (remaining_q == W'(1));
              state_q     <= S_SEND;
            end
          end
          S_SEND: begin
            if (press_c) ovr_q <= 1'b1;
            if (handshake) begin
              smp_valid_q <= 1'b0;
              remaining_q <= remaining_q - W'(1);
              if (smp_last_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_COLLECT;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign smp_valid = smp_valid_q;
  assign smp_data  = smp_data_q;
  assign smp_first = smp_first_q;
  assign smp_last  = smp_last_q;
  assign set_n     = set_n_q;
  assign abort     = abort_q;
  assign led       = {err_q, ovr_q, done_q, busy, remaining_q[3:0]};

endmodule

// File: tb/tb_entry_sequencer.sv
// Bench for entry_sequencer: directed scenarios plus random button traffic,
// every cycle compared against a transaction-level reference model.
module tb_entry_sequencer;
  localparam int MAX_N = 12;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         btnc = 1'b0, btnu = 1'b0, smp_ready = 1'b0;
  logic [W-1:0] sw = '0;
  logic         smp_valid, smp_first, smp_last, abort;
  logic [W-1:0] smp_data, set_n;
  logic [7:0]   led;

  entry_sequencer #(.MAX_N(MAX_N), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .btnc(btnc), .btnu(btnu), .sw(sw),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_first(smp_first),
    .smp_last(smp_last), .smp_ready(smp_ready), .set_n(set_n),
    .abort(abort), .led(led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Reference model: phase of the entry session plus the pending sample, if any.
  typedef enum int {P_IDLE, P_WAIT_SAMPLE, P_OFFERING, P_FINISHED} phase_t;
  phase_t m_phase;
  int     m_count, m_left, m_taken;
  bit     m_lastc, m_lastu;
  bit     m_err, m_ovr, m_done, m_abort;
  bit     m_offer, m_first, m_lastflag;
  int     m_data;
  int     hs_log[$];

  function automatic void model_reset();
    m_phase = P_IDLE; m_count = 0; m_left = 0; m_taken = 0;
    m_lastc = 1; m_lastu = 1;
    m_err = 0; m_ovr = 0; m_done = 0; m_abort = 0;
    m_offer = 0; m_first = 0; m_lastflag = 0; m_data = 0;
  endfunction

  // One clock edge of the model, using the inputs that were present at the edge.
  function automatic void model_edge(bit c, bit u, int swv, bit rdy);
    bit pc, pu, accepted;
    pc = c && !m_lastc;
    pu = u && !m_lastu;
    m_lastc = c;
    m_lastu = u;
    accepted = m_offer && rdy;
    m_abort = 0;
    if (pu) begin
      m_phase = P_IDLE; m_offer = 0; m_left = 0; m_done = 0; m_abort = 1;
      return;
    end
    if (m_phase == P_IDLE || m_phase == P_FINISHED) begin
      if (pc) begin
        if (swv >= 1 && swv <= MAX_N) begin
          m_count = swv; m_left = swv; m_taken = 0;
          m_err = 0; m_done = 0; m_ovr = 0; m_phase = P_WAIT_SAMPLE;
        end else m_err = 1;
      end
    end else if (m_phase == P_WAIT_SAMPLE) begin
      if (pc) begin
        m_offer = 1; m_data = swv;
        m_first = (m_taken == 0);
        m_lastflag = (m_taken == m_count - 1);
        m_phase = P_OFFERING;
      end
    end else begin
      if (pc) m_ovr = 1;
      if (accepted) begin
        m_offer = 0; m_taken++; m_left = m_count - m_taken;
        if (m_taken == m_count) begin m_phase = P_FINISHED; m_done = 1; end
        else m_phase = P_WAIT_SAMPLE;
      end
    end
  endfunction

  function automatic int exp_led();
    int busy;
    busy = (m_phase == P_WAIT_SAMPLE || m_phase == P_OFFERING) ? 1 : 0;
    return (int'(m_err) << 7) | (int'(m_ovr) << 6) | (int'(m_done) << 5) | (busy << 4) | (m_left & 15);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, smp_valid, m_offer);
    chk({tag, ".abort"}, abort, m_abort);
    chk({tag, ".set_n"}, set_n, m_count);
    chk({tag, ".led"}, led, exp_led());
    if (m_offer) begin
      chk({tag, ".data"}, smp_data, m_data);
      chk({tag, ".first"}, smp_first, m_first);
      chk({tag, ".last"}, smp_last, m_lastflag);
    end
  endtask

  // Advance one edge with current inputs; inputs may change after return.
  task automatic cycle(input string tag);
    bit hs;
    hs = smp_valid && smp_ready;
    if (hs) hs_log.push_back(int'(smp_data));
    @(posedge clk);
    if (reset_n) model_edge(btnc, btnu, int'(sw), smp_ready);
    #1;
    check_all(tag);
  endtask

  task automatic press(input string tag, input int v);
    btnc = 0; cycle(tag);
    sw = W'(v); btnc = 1; cycle(tag);
    btnc = 0; cycle(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 0;
    #1;
    model_reset();
    chk({tag, ".rst_valid"}, smp_valid, 0);
    chk({tag, ".rst_data"}, smp_data, 0);
    chk({tag, ".rst_first"}, smp_first, 0);
    chk({tag, ".rst_last"}, smp_last, 0);
    chk({tag, ".rst_set_n"}, set_n, 0);
    chk({tag, ".rst_abort"}, abort, 0);
    chk({tag, ".rst_led"}, led, 0);
    cycle(tag); cycle(tag);
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset("init");

    // Count 3, then samples 5,7,9 with ready held high
    smp_ready = 1;
    cycle("s1");
    hs_log.delete();
    press("s1", 3);
    press("s1", 5);
    press("s1", 7);
    press("s1", 9);
    cycle("s1");
    chk("s1.hs_count", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      chk("s1.hs0", hs_log[0], 5);
      chk("s1.hs1", hs_log[1], 7);
      chk("s1.hs2", hs_log[2], 9);
    end
    chk("s1.led_done", led, 8'h20);

    // Out-of-range counts set err, a valid count clears it
    do_reset("s2");
    press("s2", 0);
    chk("s2.err0", led[7], 1);
    press("s2", 13);
    chk("s2.err13", led[7], 1);
    chk("s2.novalid", smp_valid, 0);
    press("s2", 2);
    chk("s2.errclr", led[7], 0);
    chk("s2.busy", led[4], 1);

    // Back-pressure: sample held, extra press flags overrun
    do_reset("s3");
    smp_ready = 0;
    press("s3", 2);
    press("s3", 77);
    for (int i = 0; i < 10; i++) begin
      btnc = (i == 4); cycle("s3");
    end
    btnc = 0;
    chk("s3.held_valid", smp_valid, 1);
    chk("s3.held_data", smp_data, 77);
    chk("s3.ovr", led[6], 1);
    chk("s3.rem", led[3:0], 2);
    smp_ready = 1; cycle("s3"); cycle("s3");
    chk("s3.rem_after", led[3:0], 1);

    // Abort coincident with a sample press
    do_reset("s4");
    smp_ready = 1;
    press("s4", 4);
    press("s4", 11);
    press("s4", 12);
    btnc = 1; btnu = 1; cycle("s4");
    chk("s4.abort_hi", abort, 1);
    btnc = 0; btnu = 0; cycle("s4");
    chk("s4.abort_lo", abort, 0);
    chk("s4.rem0", led[3:0], 0);
    chk("s4.noval", smp_valid, 0);
    chk("s4.idle", led[4], 0);

    // Button held across reset release gives no press
    btnc = 1;
    do_reset("s5");
    for (int i = 0; i < 3; i++) cycle("s5");
    chk("s5.nobusy", led[4], 0);
    btnc = 0; cycle("s5");
    btnc = 1; cycle("s5");
    btnc = 0; cycle("s5");
    chk("s5.busy", led[4], 1);

    // Reset asserted mid-offer drops valid without an edge
    smp_ready = 0;
    sw = 8'd33; btnc = 1; cycle("s6");
    btnc = 0; cycle("s6");
    chk("s6.valid_pre", smp_valid, 1);
    #2;
    do_reset("s6");
    press("s6", 3);
    chk("s6.count_after", set_n, 3);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      btnc = ($urandom_range(0, 2) == 0);
      btnu = ($urandom_range(0, 60) == 0);
      smp_ready = $urandom_range(0, 1);
      sw = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 14));
      if ($urandom_range(0, 700) == 0) do_reset("rnd");
      else cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
